// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pkg
// Description : Shared helpers for the pipelined mux tree: layer count
//               (clog2, minimum 1), padded word count and a default word type.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    // Default word width used by callers that do not override W.
    localparam int c_MUX_DEF_W = 4;

    // Word type for the default width; modules with a different W declare
    // the same pattern locally as logic [W-1:0].
    typedef logic [c_MUX_DEF_W-1:0] word_t;

    // Number of 2:1 layers needed to reduce n words to one (never below 1).
    function automatic int layer_count(input int n);
        int l;
        l = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                l = i + 1;
            end
        end
        return l;
    endfunction

    // Word count after zero padding to a full binary tree.
    function automatic int padded_count(input int n);
        return 1 << layer_count(n);
    endfunction

endpackage : mux_pkg
`default_nettype wire

// File: rtl/mux_tree_stage.sv
`default_nettype none
// ============================================================================
// Module      : mux_tree_stage
// Description : One registered 2:1 layer of the mux tree. Halves the word
//               set using in_sel[0] and forwards the unused select bits and
//               the valid flag alongside the data. Loads only on advance.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_tree_stage
    import mux_pkg::*;
#(
    parameter int  N_IN    = 2,   // input word count (power of two, >= 2)
    parameter int  W       = 4,   // word width
    parameter int  SB      = 0,   // select bits left after this layer
    localparam int c_N_OUT = N_IN / 2,
    localparam int c_SO    = (SB > 0) ? SB : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  advance,
    input  logic                  in_valid,
    input  logic [N_IN*W-1:0]     in_words,
    input  logic [SB:0]           in_sel,
    output logic                  out_valid,
    output logic [c_N_OUT*W-1:0]  out_words,
    output logic [c_SO-1:0]       out_sel
);

    logic [c_N_OUT*W-1:0] w_next_words;
    logic [c_SO-1:0]      w_next_sel;

    logic                 r_valid;
    logic [c_N_OUT*W-1:0] r_words;
    logic [c_SO-1:0]      r_sel;

    // Pair (2m, 2m+1) collapses to word m; select bit 0 picks the even word.
    for (genvar m = 0; m < c_N_OUT; m++) begin : g_pair
        assign w_next_words[m*W +: W] = in_sel[0] ? in_words[(2*m+1)*W +: W]
                                                  : in_words[(2*m)*W +: W];
    end

    // The consumed LSB is dropped; the rest travels with the data.
    if (SB > 0) begin : g_sel_fwd
        assign w_next_sel = in_sel[SB:1];
    end else begin : g_sel_last
        assign w_next_sel = '0;
    end

    // Stage register: clears on reset, loads on advance, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_words <= '0;
            r_sel   <= '0;
        end else if (advance) begin
            r_valid <= in_valid;
            r_words <= w_next_words;
            r_sel   <= w_next_sel;
        end
    end

    assign out_valid = r_valid;
    assign out_words = r_words;
    assign out_sel   = r_sel;

endmodule : mux_tree_stage
`default_nettype wire

// File: rtl/mux_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mux_tree_pipe
// Description : Parametrised N-to-1 mux of W-bit words built as a binary tree
//               with a register after every layer and a global-stall
//               valid/ready handshake. Unused tree inputs read as zero, so an
//               out-of-range select yields zero. Latency is L = clog2(N).
//               Optional feature macro: MUX_PIPE_SEL_ERR_EN adds o_sel_err,
//               flagging words produced by a select s >= N.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_tree_pipe
    import mux_pkg::*;
#(
    parameter int  N   = 13,
    parameter int  W   = 4,
    localparam int L   = layer_count(N),
    localparam int c_P = padded_count(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_valid,
    output logic           i_ready,
    input  logic [N*W-1:0] a,
    input  logic [L-1:0]   s,
    output logic           o_valid,
    input  logic           o_ready,
    output logic [W-1:0]   y
`ifdef MUX_PIPE_SEL_ERR_EN
    ,
    output logic           o_sel_err
`endif
);

    logic             w_advance;
    logic [c_P*W-1:0] w_pad;

    // Whole pipe moves together: it may advance when the output slot is
    // empty or being consumed this cycle.
    assign w_advance = ~o_valid | o_ready;
    assign i_ready   = w_advance;

    // Zero padding up to a full tree is what makes s >= N return zero.
    if (c_P > N) begin : g_pad
        assign w_pad = {{((c_P - N) * W){1'b0}}, a};
    end else begin : g_nopad
        assign w_pad = a;
    end

    for (genvar j = 1; j <= L; j++) begin : g_layer
        localparam int c_NI = c_P >> (j - 1);
        localparam int c_SB = L - j;
        localparam int c_SO = (c_SB > 0) ? c_SB : 1;

        logic                   w_in_valid;
        logic [c_NI*W-1:0]      w_in_words;
        logic [c_SB:0]          w_in_sel;
        logic                   w_out_valid;
        logic [(c_NI/2)*W-1:0]  w_out_words;
        logic [c_SO-1:0]        w_out_sel;

        if (j == 1) begin : g_first
            assign w_in_valid = i_valid;
            assign w_in_words = w_pad;
            assign w_in_sel   = s;
        end else begin : g_next
            assign w_in_valid = g_layer[j-1].w_out_valid;
            assign w_in_words = g_layer[j-1].w_out_words;
            assign w_in_sel   = g_layer[j-1].w_out_sel;
        end

        mux_tree_stage #(
            .N_IN (c_NI),
            .W    (W),
            .SB   (c_SB)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .advance   (w_advance),
            .in_valid  (w_in_valid),
            .in_words  (w_in_words),
            .in_sel    (w_in_sel),
            .out_valid (w_out_valid),
            .out_words (w_out_words),
            .out_sel   (w_out_sel)
        );
    end

    assign o_valid = g_layer[L].w_out_valid;
    assign y       = g_layer[L].w_out_words;

`ifdef MUX_PIPE_SEL_ERR_EN
    logic         w_sel_err;
    logic [L-1:0] r_err;

    // Out-of-range detection on the raw select; only valid words may flag.
    assign w_sel_err = i_valid & (32'(s) >= 32'(N));

    // Error flag rides a shift chain in lockstep with the data stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= '0;
        end else if (w_advance) begin
            r_err[0] <= w_sel_err;
            for (int k = 1; k < L; k++) begin
                r_err[k] <= r_err[k-1];
            end
        end
    end

    assign o_sel_err = r_err[L-1];
`endif

endmodule : mux_tree_pipe
`default_nettype wire
